mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The module SHALL use parameter WIDTH, default 16, as the data width of the bus, MAR-side data, MDR and memory data.
REQ-002 The module SHALL use parameter AW, default 16, as the address width; MAR holds the low AW bits of bus_in.
REQ-003 The module SHALL use parameter TIMEOUT, default 15, range 1..255, as the maximum number of cycles it waits for mem_ack.
REQ-004 The module SHALL have one clock and a synchronous, active-high reset. Ports, clock and reset first:
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ld_mar  in  1  load MAR from bus_in.
- ld_mdr  in  1  load MDR (source per REQ-010).
- mio_en  in  1  request a memory cycle at MAR.
- r_w  in  1  0 = read, 1 = write; sampled when the cycle starts.
- bus_in  in  WIDTH  global bus value.
- mar_out  out  AW  current MAR.
- mdr_out  out  WIDTH  current MDR (drives GateMDR).
- ready  out  1  R: one-cycle pulse when the access completes.
- err  out  1  sticky timeout flag.
- mem_req  out  1  external request, held until ack or timeout.
- mem_we  out  1  external write enable; valid with mem_req.
- mem_addr  out  AW  external address; equals MAR.
- mem_wdata  out  WIDTH  external write data; equals MDR.
- mem_rdata  in  WIDTH  external read data; valid with mem_ack.
- mem_ack  in  1  external completion strobe.
- kbd_valid  in  1  keyboard has a character (MMIO_EN only).
- kbd_data  in  8  keyboard character (MMIO_EN only).
- disp_ready  in  1  display can accept a character (MMIO_EN only).
- disp_valid  out  1  one-cycle display write strobe (MMIO_EN only).
- disp_data  out  8  display character (MMIO_EN only).

Function
REQ-005 The FSM SHALL have states IDLE, ACCESS and DONE.
REQ-006 IDLE->ACCESS SHALL occur when mio_en=1; r_w and MAR SHALL be captured on that edge.
REQ-007 In ACCESS, mem_req SHALL be 1, and mem_we SHALL equal the captured r_w.
REQ-008 ACCESS->DONE SHALL occur on the first edge where mem_ack=1, or when the wait counter reaches TIMEOUT; on timeout err SHALL be set.
REQ-009 In DONE, ready SHALL be 1 for exactly one cycle; DONE->IDLE SHALL be unconditional. Minimum read/write latency SHALL be 2 cycles from mio_en to ready.
REQ-010 ld_mdr with mio_en=0 SHALL load MDR from bus_in. On a read, MDR SHALL load mem_rdata on the acking edge regardless of ld_mdr. On a timed-out read, MDR SHALL load all ones.
REQ-011 ld_mar and ld_mdr SHALL be ignored while the state is ACCESS. mio_en while in ACCESS or DONE SHALL NOT start a new cycle.
REQ-012 The wait counter SHALL be 8 bits, SHALL clear on entry to ACCESS, SHALL increment each ACCESS cycle, and SHALL saturate (no wrap).
REQ-013 mem_ack outside ACCESS SHALL be ignored.
REQ-014 err SHALL clear only on reset or on the start of the next successful-ack cycle's entry to ACCESS.

Reset
REQ-015 Reset SHALL force state=IDLE, MAR=0x3000 (truncated to AW), MDR=0, counter=0, err=0, ready=0, mem_req=0, mem_we=0, disp_valid=0, disp_data=0, KBSR=0. Reset mid-ACCESS SHALL abandon the cycle with no ready pulse.

Configuration
REQ-016 The macro MMIO_EN SHALL control memory-mapped I/O.
- Defined: addresses 0xFE00 KBSR, 0xFE02 KBDR, 0xFE04 DSR and 0xFE06 DDR (for AW=16) SHALL be serviced internally with no mem_req; the FSM goes ACCESS->DONE on the next edge.
  - KBSR[15] SHALL latch on kbd_valid; a KBDR read returns {0, kbd_data} and clears KBSR[15].
  - A DSR read returns {disp_ready, 0}.
  - A DDR write pulses disp_valid for one cycle with disp_data=MDR[7:0].
- Undefined: all addresses SHALL go external; kbd_*/disp_* inputs are unused and disp_valid=0, disp_data=0.

Verification
REQ-017 Read 0x3000 with mem_ack two cycles after mem_req, mem_rdata=0x1234 -> ready pulses once, MDR=0x1234, err=0.
REQ-018 ld_mdr with bus_in=0xBEEF, then write to 0x4000 -> mem_we=1, mem_addr=0x4000, mem_wdata=0xBEEF until ack; ready follows.
REQ-019 Read with mem_ack never asserted, TIMEOUT=15 -> ready on the cycle after 15 ACCESS cycles, err=1, MDR=0xFFFF.
REQ-020 Assert reset during ACCESS -> next cycle state IDLE, mem_req=0, MAR=0x3000, no ready pulse.
REQ-021 MMIO_EN: kbd_valid with kbd_data=0x41, read 0xFE00 then 0xFE02 -> MDR=0x8000 then 0x0041, KBSR[15]=0, mem_req never asserted.
REQ-022 MMIO_EN: write 0x0058 to 0xFE06 -> disp_valid one cycle, disp_data=0x58.

Source files
------------

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Purpose:
//   MAR/MDR front end for a simple CPU datapath. It runs one memory cycle at a
//   time through an IDLE -> ACCESS -> DONE handshake with an external memory
//   (mem_req/mem_ack). A wait counter bounds each access: if no ack arrives in
//   TIMEOUT cycles, the access ends anyway and the sticky err flag is set.
//
// Configuration:
//   MMIO_EN (macro) - when defined, the addresses KBSR 0xFE00, KBDR 0xFE02,
//   DSR 0xFE04 and DDR 0xFE06 are serviced inside this block and never reach
//   the external bus. When undefined, every address goes external, the kbd_* and
//   disp_ready inputs are unused, and disp_valid/disp_data are held at zero.
//
// Parameters:
//   WIDTH   - data width of bus, MDR and memory data (default 16)
//   AW      - address width; MAR holds bus_in[AW-1:0] (default 16, AW <= WIDTH)
//   TIMEOUT - cycles to wait for mem_ack, 1..255 (default 15)
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   ld_mar, ld_mdr      - load MAR / MDR from bus_in (ignored during ACCESS)
//   mio_en, r_w         - start a memory cycle at MAR; r_w 0 = read, 1 = write
//   bus_in              - global bus value
//   mar_out, mdr_out    - current MAR and MDR
//   ready               - one-cycle pulse when an access completes
//   err                 - sticky timeout flag
//   mem_req/we/addr/wdata, mem_rdata, mem_ack - external memory handshake
//   kbd_valid, kbd_data - keyboard character source (MMIO_EN only)
//   disp_ready          - display can take a character (MMIO_EN only)
//   disp_valid, disp_data - one-cycle display write strobe and data (MMIO_EN only)
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int WIDTH   = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_mar,
  input  logic             ld_mdr,
  input  logic             mio_en,
  input  logic             r_w,
  input  logic [WIDTH-1:0] bus_in,
  output logic [AW-1:0]    mar_out,
  output logic [WIDTH-1:0] mdr_out,
  output logic             ready,
  output logic             err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  input  logic             kbd_valid,
  input  logic [7:0]       kbd_data,
  input  logic             disp_ready,
  output logic             disp_valid,
  output logic [7:0]       disp_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [AW-1:0] MAR_RESET    = AW'(16'h3000);
  // Counter value seen during the last permitted ACCESS cycle.
  localparam logic [7:0]    TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [AW-1:0]    mar;
  logic [WIDTH-1:0] mdr;
  logic             rw_q;       // r_w captured when the cycle starts
  logic [7:0]       wait_cnt;
  logic             err_q;

  // MMIO decode results, defined by whichever configuration is built.
  logic             is_mmio;    // MAR points at an internal register
  logic [WIDTH-1:0] mmio_rdata; // value an internal read returns

  logic in_access;
  logic start;
  logic timeout_hit;
  logic ext_ack;
  logic ext_timeout;

  assign in_access   = (state == ACCESS);
  assign start       = (state == IDLE) && mio_en;
  assign timeout_hit = (wait_cnt >= TIMEOUT_LAST);
  // External ack/timeout only matter for accesses that actually went external.
  assign ext_ack     = in_access && !is_mmio && mem_ack;
  assign ext_timeout = in_access && !is_mmio && !mem_ack && timeout_hit;

  // ---------------------------------------------------------------------------
  // Next-state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_nxt = state;
    ready     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    unique case (state)
      IDLE: begin
        if (mio_en) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_req = !is_mmio;
        mem_we  = rw_q && !is_mmio;
        // Internal registers answer immediately; external accesses end on the
        // first ack, or give up once the wait budget is spent.
        if (is_mmio || mem_ack || timeout_hit) state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, MAR, MDR, wait counter, error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before this edge, independent of statement order.
    if (reset) begin
      state    <= IDLE;
      mar      <= MAR_RESET;
      mdr      <= '0;
      rw_q     <= 1'b0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;

      // A new cycle captures its direction and restarts the wait budget. err
      // clears here; a cycle that later times out sets it again.
      if (start) begin
        rw_q     <= r_w;
        wait_cnt <= '0;
        err_q    <= 1'b0;
      end else if (in_access && wait_cnt != 8'hFF) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (ext_timeout) err_q <= 1'b1;

      // MAR is frozen for the whole ACCESS state so mem_addr stays stable.
      if (ld_mar && !in_access) mar <= bus_in[AW-1:0];

      // Read completion owns MDR during ACCESS; bus loads are blocked there and
      // whenever mio_en is asserted alongside ld_mdr.
      if (in_access) begin
        if (!rw_q) begin
          if (is_mmio)          mdr <= mmio_rdata;
          else if (mem_ack)     mdr <= mem_rdata;
          else if (timeout_hit) mdr <= '1;
        end
      end else if (ld_mdr && !mio_en) begin
        mdr <= bus_in;
      end
    end
  end

  assign mar_out   = mar;
  assign mdr_out   = mdr;
  assign mem_addr  = mar;
  assign mem_wdata = mdr;
  assign err       = err_q;

`ifdef MMIO_EN
  // ---------------------------------------------------------------------------
  // Memory-mapped keyboard and display registers
  // ---------------------------------------------------------------------------
  localparam logic [AW-1:0] KBSR_ADDR = AW'(16'hFE00);
  localparam logic [AW-1:0] KBDR_ADDR = AW'(16'hFE02);
  localparam logic [AW-1:0] DSR_ADDR  = AW'(16'hFE04);
  localparam logic [AW-1:0] DDR_ADDR  = AW'(16'hFE06);

  logic       kbsr_ready;   // KBSR bit 15: a keyboard character is waiting
  logic       disp_valid_q;
  logic [7:0] disp_data_q;
  logic       mmio_fire;    // the single ACCESS cycle of an internal access

  assign is_mmio   = (mar == KBSR_ADDR) || (mar == KBDR_ADDR) ||
                     (mar == DSR_ADDR)  || (mar == DDR_ADDR);
  assign mmio_fire = in_access && is_mmio;

  // Reads of DDR (write-only) return zero.
  always_comb begin
    mmio_rdata = '0;
    if (mar == KBSR_ADDR)     mmio_rdata = {kbsr_ready, {(WIDTH-1){1'b0}}};
    else if (mar == KBDR_ADDR) mmio_rdata = WIDTH'(kbd_data);
    else if (mar == DSR_ADDR)  mmio_rdata = {disp_ready, {(WIDTH-1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kbsr_ready   <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      // Reading KBDR consumes the character; a new kbd_valid on the same edge
      // wins so that character is not lost.
      if (mmio_fire && !rw_q && mar == KBDR_ADDR) kbsr_ready <= 1'b0;
      if (kbd_valid)                              kbsr_ready <= 1'b1;

      disp_valid_q <= mmio_fire && rw_q && (mar == DDR_ADDR);
      if (mmio_fire && rw_q && mar == DDR_ADDR) disp_data_q <= mdr[7:0];
    end
  end

  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;
`else
  // Every address is external; the I/O pins are inert.
  logic unused_mmio_inputs;
  assign unused_mmio_inputs = ^{kbd_valid, kbd_data, disp_ready};

  assign is_mmio    = 1'b0;
  assign mmio_rdata = '0;
  assign disp_valid = 1'b0;
  assign disp_data  = '0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Randomized scoreboard bench for mem_access_unit. The driver plays CPU and
// memory; for every access it predicts, from the access rules alone, the MDR
// value, the err flag and the cycle on which ready must pulse, and queues that
// prediction. A monitor pops a prediction at every ready pulse and compares.
// Builds with or without MMIO_EN; the MMIO directed cases run only when defined.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int WIDTH   = 16;
  localparam int AW      = 16;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic             ld_mar, ld_mdr, mio_en, r_w;
  logic [WIDTH-1:0] bus_in;
  logic [AW-1:0]    mar_out;
  logic [WIDTH-1:0] mdr_out;
  logic             ready, err;
  logic             mem_req, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata, mem_rdata;
  logic             mem_ack;
  logic             kbd_valid;
  logic [7:0]       kbd_data;
  logic             disp_ready;
  logic             disp_valid;
  logic [7:0]       disp_data;

  mem_access_unit #(.WIDTH(WIDTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_mar     (ld_mar),
    .ld_mdr     (ld_mdr),
    .mio_en     (mio_en),
    .r_w        (r_w),
    .bus_in     (bus_in),
    .mar_out    (mar_out),
    .mdr_out    (mdr_out),
    .ready      (ready),
    .err        (err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .kbd_valid  (kbd_valid),
    .kbd_data   (kbd_data),
    .disp_ready (disp_ready),
    .disp_valid (disp_valid),
    .disp_data  (disp_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [WIDTH-1:0] mdr;
    logic             err;
    int               at;
  } exp_t;

  exp_t sb[$];

  // Architectural model of the visible registers.
  logic [AW-1:0]    mar_m;
  logic [WIDTH-1:0] mdr_m;
  logic             err_m;
  logic [7:0]       disp_exp;
  int               disp_exp_cnt = 0;
  int               disp_seen    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_ready: ready pulsed with no access outstanding (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("ready_mdr", 32'(mdr_out), 32'(e.mdr));
          check("ready_err", 32'(err), 32'(e.err));
          check("ready_cycle", 32'(cyc), 32'(e.at));
        end
      end
      if (disp_valid === 1'b1) begin
        disp_seen++;
        check("disp_data", 32'(disp_data), 32'(disp_exp));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic set_mar(input logic [AW-1:0] a);
    @(negedge clk);
    ld_mar = 1'b1;
    bus_in = WIDTH'(a);
    @(negedge clk);
    ld_mar = 1'b0;
    mar_m  = a;
    check("mar_load", 32'(mar_out), 32'(mar_m));
  endtask

  task automatic set_mdr(input logic [WIDTH-1:0] d);
    @(negedge clk);
    ld_mdr = 1'b1;
    bus_in = d;
    @(negedge clk);
    ld_mdr = 1'b0;
    mdr_m  = d;
    check("mdr_load", 32'(mdr_out), 32'(mdr_m));
  endtask

  // While an access is in flight, optionally hammer the control inputs the
  // unit must ignore.
  task automatic apply_noise(input bit noise);
    if (noise) begin
      ld_mar = 1'b1;
      ld_mdr = 1'b1;
      mio_en = 1'b1;
      bus_in = WIDTH'($urandom);
    end
  endtask

  // One access. d = ACCESS cycles before ack (d >= TIMEOUT means no ack);
  // rd = read data returned (or the expected internal register value).
  task automatic do_access(input logic rw, input int d, input logic [WIDTH-1:0] rd,
                           input bit mmio, input bit noise);
    bit acked;
    int lat;
    int n_wait;
    acked = !mmio && (d < TIMEOUT);
    if (mmio) begin
      lat = 2;
      if (!rw) mdr_m = rd;
      err_m = 1'b0;
    end else if (acked) begin
      lat = d + 2;
      if (!rw) mdr_m = rd;
      err_m = 1'b0;
    end else begin
      lat = TIMEOUT + 1;
      if (!rw) mdr_m = '1;
      err_m = 1'b1;
    end
    n_wait = mmio ? 0 : (acked ? d : TIMEOUT - 1);

    @(negedge clk);
    mio_en = 1'b1;
    r_w    = rw;
    sb.push_back('{mdr: mdr_m, err: err_m, at: cyc + lat});

    @(negedge clk);
    mio_en = 1'b0;
    check("access_req", 32'(mem_req), 32'(!mmio));
    check("access_we", 32'(mem_we), 32'(rw && !mmio));
    check("access_addr", 32'(mem_addr), 32'(mar_m));
    if (rw && !mmio) check("access_wdata", 32'(mem_wdata), 32'(mdr_m));
    apply_noise(noise);

    for (int k = 0; k < n_wait; k++) begin
      @(negedge clk);
      check("hold_req", 32'(mem_req), 32'(!mmio));
      check("hold_addr", 32'(mem_addr), 32'(mar_m));
      apply_noise(noise);
    end
    if (acked) begin
      mem_ack   = 1'b1;
      mem_rdata = rd;
    end

    @(negedge clk);  // DONE
    mem_ack   = 1'b0;
    mem_rdata = WIDTH'($urandom);
    ld_mar    = 1'b0;
    ld_mdr    = 1'b0;
    mio_en    = noise;

    @(negedge clk);  // back in IDLE; mio_en during DONE must not have started a cycle
    mio_en = 1'b0;
    check("idle_req", 32'(mem_req), 32'h0);
    check("idle_mar", 32'(mar_out), 32'(mar_m));

    if (!acked && !mmio) begin
      // A late ack arriving in IDLE must be ignored.
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("stray_ack_req", 32'(mem_req), 32'h0);
      check("stray_ack_mdr", 32'(mdr_out), 32'(mdr_m));
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    int            d;
    int            sel;

    reset      = 1'b1;
    ld_mar     = 1'b0;
    ld_mdr     = 1'b0;
    mio_en     = 1'b0;
    r_w        = 1'b0;
    bus_in     = '0;
    mem_rdata  = '0;
    mem_ack    = 1'b0;
    kbd_valid  = 1'b0;
    kbd_data   = '0;
    disp_ready = 1'b0;
    disp_exp   = '0;

    repeat (2) @(negedge clk);
    check("rst_mar", 32'(mar_out), 32'h3000);
    check("rst_mdr", 32'(mdr_out), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_we", 32'(mem_we), 32'h0);
    check("rst_disp_valid", 32'(disp_valid), 32'h0);
    check("rst_disp_data", 32'(disp_data), 32'h0);
    reset = 1'b0;
    mar_m = 16'h3000;
    mdr_m = '0;
    err_m = 1'b0;

    // Read 0x3000, ack two cycles after mem_req rises.
    do_access(1'b0, 2, 16'h1234, 1'b0, 1'b0);
    // Write 0xBEEF to 0x4000.
    set_mdr(16'hBEEF);
    set_mar(16'h4000);
    do_access(1'b1, 1, 16'h0000, 1'b0, 1'b0);
    // Read timeout: MDR all ones, err sticky afterwards.
    set_mar(16'h5000);
    do_access(1'b0, TIMEOUT + 5, 16'h0000, 1'b0, 1'b0);
    check("err_sticky", 32'(err), 32'h1);
    // Ack on the last permitted cycle wins over the timeout; ignored inputs toggled.
    do_access(1'b0, TIMEOUT - 1, 16'hA5A5, 1'b0, 1'b1);
    // Minimum-latency write, then a write timeout with noise.
    set_mdr(16'h0F0F);
    do_access(1'b1, 0, 16'h0000, 1'b0, 1'b1);
    do_access(1'b1, TIMEOUT + 1, 16'h0000, 1'b0, 1'b1);

    // Reset in the middle of an access: cycle abandoned, no ready pulse.
    set_mar(16'h6000);
    @(negedge clk);
    mio_en = 1'b1;
    r_w    = 1'b0;
    @(negedge clk);
    mio_en = 1'b0;
    check("pre_reset_req", 32'(mem_req), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mar_m = 16'h3000;
    mdr_m = '0;
    err_m = 1'b0;
    check("midrst_req", 32'(mem_req), 32'h0);
    check("midrst_mar", 32'(mar_out), 32'(mar_m));
    check("midrst_mdr", 32'(mdr_out), 32'h0);
    check("midrst_err", 32'(err), 32'h0);
    check("midrst_ready", 32'(ready), 32'h0);
    @(negedge clk);
    check("midrst_ready_next", 32'(ready), 32'h0);

    // Randomized accesses.
    for (int i = 0; i < 40; i++) begin
      a = AW'($urandom);
      if (a[15:9] == 7'h7F) a[15] = 1'b0;  // stay clear of the I/O page
      set_mar(a);
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      d = TIMEOUT + int'($urandom_range(0, 4));
      else if (sel == 1) d = TIMEOUT - 1;
      else               d = int'($urandom_range(0, 6));
      if ($urandom_range(0, 1) == 1) begin
        set_mdr(WIDTH'($urandom));
        do_access(1'b1, d, 16'h0000, 1'b0, bit'($urandom_range(0, 1)));
      end else begin
        do_access(1'b0, d, WIDTH'($urandom), 1'b0, bit'($urandom_range(0, 1)));
      end
    end

`ifdef MMIO_EN
    kbd_data = 8'h41;
    @(negedge clk);
    kbd_valid = 1'b1;
    @(negedge clk);
    kbd_valid = 1'b0;
    set_mar(16'hFE00);
    do_access(1'b0, 0, 16'h8000, 1'b1, 1'b0);
    set_mar(16'hFE02);
    do_access(1'b0, 0, 16'h0041, 1'b1, 1'b0);
    set_mar(16'hFE00);
    do_access(1'b0, 0, 16'h0000, 1'b1, 1'b0);
    disp_ready = 1'b1;
    set_mar(16'hFE04);
    do_access(1'b0, 0, 16'h8000, 1'b1, 1'b0);
    set_mdr(16'h0058);
    set_mar(16'hFE06);
    disp_exp = 8'h58;
    disp_exp_cnt++;
    do_access(1'b1, 0, 16'h0000, 1'b1, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    check("disp_pulses", 32'(disp_seen), 32'(disp_exp_cnt));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
